dram_arbiter: RTL and testbench
===============================

// Module: dram_arbiter
// PURPOSE
//  Shares the single-port data RAM between three requesters: CPU MA stage (P0), DMA engine (P1), debug/monitor port (P2).
//  Sits between ma_stage/dma/monitor and the data RAM macro. P0 has fixed priority; P1/P2 alternate round-robin.
//  A starvation counter briefly holds the CPU pipeline so DMA/debug always make progress.
// PARAMETERS
//  DWIDTH     12  data RAM byte-address width; word address is [DWIDTH+1:2]
//  STARVE_MAX 8   cycles a P1/P2 request may wait before a forced grant (2..255)
// PORTS
//  clk          in   1         system clock
//  rst_n        in   1         asynchronous active-low reset
//  cpu_req      in   1         P0 access request (single cycle)
//  cpu_we       in   1         P0 write enable
//  cpu_adr      in   DWIDTH    P0 word address [DWIDTH+1:2]
//  cpu_wdata    in   32        P0 write data
//  cpu_hold     out  1         stall request to cpu_status; P0 must keep cpu_req/adr stable
//  dma_req      in   1         P1 request; held until dma_gnt
//  dma_we       in   1         P1 write enable
//  dma_adr      in   DWIDTH    P1 word address
//  dma_wdata    in   32        P1 write data
//  dma_gnt      out  1         P1 granted this cycle
//  dbg_req/dbg_we/dbg_adr/dbg_wdata/dbg_gnt   same as P1, for P2
//  ram_en       out  1         RAM access strobe
//  ram_we       out  1         RAM write enable
//  ram_adr      out  DWIDTH    RAM word address
//  ram_wdata    out  32        RAM write data
//  ram_rdata    in   32        RAM read data, valid 1 cycle after ram_en&!ram_we
//  rdata        out  32        read data returned to all requesters (ram_rdata passthrough)
//  rvalid       out  3         one-hot read-return tag {P2,P1,P0}, 1 cycle after read grant
//  perf_gnt1    out  16        P1 grant count (optional feature)
//  perf_conf    out  16        conflict cycles, >1 request pending (optional feature)
// BEHAVIOUR
//  Reset: state=ARB, rr_ptr=P1, starve_cnt=0, rvalid=0, cpu_hold=0; all gnt/ram_* outputs 0.
//  Grant is combinational in cycle N; ram_* driven from winner in cycle N; rvalid[winner] registered, high in N+1.
//  State ARB: cpu_req wins if present. Else P1/P2 winner chosen by rr_ptr; rr_ptr flips after each P1/P2 grant.
//   starve_cnt increments each cycle a P1/P2 request is pending but not granted; clears on any P1/P2 grant or no pending.
//   starve_cnt==STARVE_MAX-1 with pending P1/P2 -> next state HOLD (counter saturates, no wrap).
//  State HOLD (exactly 1 cycle): cpu_hold=1, P0 ignored, the rr_ptr-selected pending P1/P2 granted; -> ARB, starve_cnt=0.
//   If the P1/P2 request dropped before HOLD, HOLD grants nothing, still lasts 1 cycle.
//  Only one grant per cycle; ram_en = |grants. Write grants never set rvalid.
//  Simultaneous P1+P2 with no P0: rr_ptr decides; same requester cannot win twice in a row while other waits.
//  Reset mid-access: pending rvalid cleared; RAM data of in-flight read discarded.
// CONFIGURATION
//  DRAM_ARB_PERF_EN defined: perf_gnt1/perf_conf count from 0, saturate at 16'hFFFF, cleared by reset.
//  Not defined: perf_gnt1=perf_conf=0 constant; no counter flops synthesized.
// TESTING
//  cpu_req read adr 0x10 alone -> ram_en=1, ram_adr=0x10 same cycle; rvalid=3'b001 next cycle, rdata=RAM[0x10].
//  dma_req+dbg_req both held, no cpu -> grants alternate P1,P2,P1,...; rr_ptr starts P1 after reset.
//  cpu_req continuous + dma_req held, STARVE_MAX=8 -> cpu_hold=1 on cycle 8, dma_gnt same cycle, then cpu resumes.
//  dbg write 0xDEADBEEF to 0x20 then cpu read 0x20 -> rdata=0xDEADBEEF, rvalid=3'b001.
//  rst_n low cycle after dma read grant -> rvalid stays 0, state ARB, starve_cnt=0.
//  DRAM_ARB_PERF_EN: 5 dma grants with 3 conflict cycles -> perf_gnt1=5, perf_conf=3; undefined -> both 0.

Source files
------------

// File: rtl/dram_arbiter.sv
// Data-RAM arbiter: CPU (P0) fixed priority, DMA/debug (P1/P2) round-robin with starvation hold.
// Optional performance counters are built when DRAM_ARB_PERF_EN is defined.
module dram_arbiter #(
    parameter int DWIDTH     = 12,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [DWIDTH-1:0] cpu_adr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_hold,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [DWIDTH-1:0] dma_adr,
    input  logic [31:0]       dma_wdata,
    output logic              dma_gnt,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [DWIDTH-1:0] dbg_adr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_gnt,
    output logic              ram_en,
    output logic              ram_we,
    output logic [DWIDTH-1:0] ram_adr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       rdata,
    output logic [2:0]        rvalid,
    output logic [15:0]       perf_gnt1,
    output logic [15:0]       perf_conf
);

    typedef enum logic {ARB, HOLD} state_t;

    localparam logic [7:0] STARVE_LAST = 8'(STARVE_MAX - 1);

    state_t     state, state_nxt;
    logic       rr_ptr, rr_nxt;         // 0: P1 preferred, 1: P2 preferred
    logic [7:0] starve_cnt, starve_nxt;
    logic       cpu_gnt;
    logic       pend;
    logic       pick_dbg;

    assign pend     = dma_req | dbg_req;
    assign pick_dbg = dbg_req & (rr_ptr | ~dma_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB;
            rr_ptr     <= 1'b0;
            starve_cnt <= 8'd0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rr_nxt     = rr_ptr;
        starve_nxt = starve_cnt;
        cpu_gnt    = 1'b0;
        dma_gnt    = 1'b0;
        dbg_gnt    = 1'b0;
        cpu_hold   = 1'b0;
        case (state)
            ARB: begin
                if (cpu_req) begin
                    cpu_gnt = 1'b1;
                    if (pend) begin
                        // P1/P2 lost to the CPU: count, and force a hold at the limit
                        if (starve_cnt == STARVE_LAST) state_nxt = HOLD;
                        else                           starve_nxt = starve_cnt + 8'd1;
                    end else begin
                        starve_nxt = 8'd0;
                    end
                end else begin
                    dma_gnt    = pend & ~pick_dbg;
                    dbg_gnt    = pick_dbg;
                    starve_nxt = 8'd0;
                end
            end
            HOLD: begin
                cpu_hold   = 1'b1;
                dma_gnt    = pend & ~pick_dbg;
                dbg_gnt    = pick_dbg;
                starve_nxt = 8'd0;
                state_nxt  = ARB;
            end
            default: state_nxt = ARB;
        endcase
        // point at the loser so the same requester never wins twice while the other waits
        if (dma_gnt) rr_nxt = 1'b1;
        if (dbg_gnt) rr_nxt = 1'b0;
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_adr   = '0;
        ram_wdata = '0;
        if (cpu_gnt) begin
            ram_we    = cpu_we;
            ram_adr   = cpu_adr;
            ram_wdata = cpu_wdata;
        end else if (dma_gnt) begin
            ram_we    = dma_we;
            ram_adr   = dma_adr;
            ram_wdata = dma_wdata;
        end else if (dbg_gnt) begin
            ram_we    = dbg_we;
            ram_adr   = dbg_adr;
            ram_wdata = dbg_wdata;
        end
    end

    assign ram_en = cpu_gnt | dma_gnt | dbg_gnt;
    assign rdata  = ram_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rvalid <= 3'b000;
        else        rvalid <= {dbg_gnt & ~dbg_we, dma_gnt & ~dma_we, cpu_gnt & ~cpu_we};
    end

`ifdef DRAM_ARB_PERF_EN
    logic conflict;
    assign conflict = (cpu_req & dma_req) | (cpu_req & dbg_req) | (dma_req & dbg_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_gnt1 <= 16'd0;
            perf_conf <= 16'd0;
        end else begin
            if (dma_gnt && perf_gnt1 != 16'hFFFF)  perf_gnt1 <= perf_gnt1 + 16'd1;
            if (conflict && perf_conf != 16'hFFFF) perf_conf <= perf_conf + 16'd1;
        end
    end
`else
    assign perf_gnt1 = 16'd0;
    assign perf_conf = 16'd0;
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: vector table for single-cycle arbitration plus
// sequences for read return, starvation hold, reset mid-read and perf counters.
module tb_dram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, dma_req, dma_we, dbg_req, dbg_we;
    logic [11:0] cpu_adr, dma_adr, dbg_adr;
    logic [31:0] cpu_wdata, dma_wdata, dbg_wdata;
    logic        cpu_hold, dma_gnt, dbg_gnt, ram_en, ram_we;
    logic [11:0] ram_adr;
    logic [31:0] ram_wdata, ram_rdata, rdata;
    logic [2:0]  rvalid;
    logic [15:0] perf_gnt1, perf_conf;

    logic [31:0] mem [0:4095];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dram_arbiter #(.DWIDTH(12), .STARVE_MAX(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_hold(cpu_hold),
        .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
        .ram_en(ram_en), .ram_we(ram_we), .ram_adr(ram_adr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .rdata(rdata), .rvalid(rvalid), .perf_gnt1(perf_gnt1), .perf_conf(perf_conf)
    );

    // Behavioural single-port RAM with one-cycle read latency
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_adr] <= ram_wdata;
            else        ram_rdata <= mem[ram_adr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; dma_req = 0; dma_we = 0; dbg_req = 0; dbg_we = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic cr, cw, dr, dw, br, bw;
        logic hold, dgnt, bgnt, en, we;
        logic [11:0] adr;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{0,0, 0,0, 0,0,  0,0,0,0,0, 12'h000};
        vecs[1]  = '{1,0, 0,0, 0,0,  0,0,0,1,0, 12'h010};
        vecs[2]  = '{0,0, 1,0, 1,0,  0,1,0,1,0, 12'h011};
        vecs[3]  = '{0,0, 1,0, 1,0,  0,0,1,1,0, 12'h012};
        vecs[4]  = '{0,0, 1,0, 1,0,  0,1,0,1,0, 12'h011};
        vecs[5]  = '{0,0, 1,0, 0,0,  0,1,0,1,0, 12'h011};
        vecs[6]  = '{0,0, 0,0, 1,1,  0,0,1,1,1, 12'h012};
        vecs[7]  = '{1,0, 1,0, 0,0,  0,0,0,1,0, 12'h010};
        vecs[8]  = '{0,0, 0,0, 0,0,  0,0,0,0,0, 12'h000};
        vecs[9]  = '{1,1, 0,0, 0,0,  0,0,0,1,1, 12'h010};
        vecs[10] = '{0,0, 1,0, 1,0,  0,1,0,1,0, 12'h011};
        vecs[11] = '{0,0, 0,0, 1,0,  0,0,1,1,0, 12'h012};

        cpu_adr = 12'h010; dma_adr = 12'h011; dbg_adr = 12'h012;
        cpu_wdata = 32'hC0C0_0000; dma_wdata = 32'hD1D1_0000; dbg_wdata = 32'hB2B2_0000;
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset_rvalid", 32'(rvalid), 0);
        chk("reset_hold", 32'(cpu_hold), 0);
        chk("reset_ram_en", 32'(ram_en), 0);
        chk("reset_gnts", 32'({dma_gnt, dbg_gnt}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: arbitration decisions from a fresh reset (rr_ptr at P1)
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            cpu_req = vecs[i].cr; cpu_we = vecs[i].cw;
            dma_req = vecs[i].dr; dma_we = vecs[i].dw;
            dbg_req = vecs[i].br; dbg_we = vecs[i].bw;
            #1;
            chk($sformatf("v%0d_hold", i), 32'(cpu_hold), 32'(vecs[i].hold));
            chk($sformatf("v%0d_dma_gnt", i), 32'(dma_gnt), 32'(vecs[i].dgnt));
            chk($sformatf("v%0d_dbg_gnt", i), 32'(dbg_gnt), 32'(vecs[i].bgnt));
            chk($sformatf("v%0d_ram_en", i), 32'(ram_en), 32'(vecs[i].en));
            chk($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].we));
            chk($sformatf("v%0d_ram_adr", i), 32'(ram_adr), 32'(vecs[i].adr));
        end

        // Debug write then CPU read of the same word
        @(negedge clk);
        idle_inputs();
        dbg_req = 1; dbg_we = 1; dbg_adr = 12'h020; dbg_wdata = 32'hDEADBEEF;
        #1;
        chk("dbgw_gnt", 32'(dbg_gnt), 1);
        chk("dbgw_wdata", ram_wdata, 32'hDEADBEEF);
        @(negedge clk);
        idle_inputs();
        cpu_req = 1; cpu_adr = 12'h020;
        #1;
        chk("cpur_adr", 32'(ram_adr), 32'h020);
        @(posedge clk);
        #1;
        chk("cpur_rvalid", 32'(rvalid), 32'b001);
        chk("cpur_rdata", rdata, 32'hDEADBEEF);

        // DMA read return tag
        @(negedge clk);
        idle_inputs();
        dma_req = 1; dma_adr = 12'h020;
        @(posedge clk);
        #1;
        chk("dmar_rvalid", 32'(rvalid), 32'b010);
        chk("dmar_rdata", rdata, 32'hDEADBEEF);

        // Starvation: CPU continuous, DMA held; hold lands on cycle 8
        do_reset();
        cpu_adr = 12'h030; dma_adr = 12'h031;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            cpu_req = 1; dma_req = 1;
            #1;
            chk($sformatf("starve%0d_gnt", c), 32'({cpu_hold, dma_gnt}), 0);
            chk($sformatf("starve%0d_adr", c), 32'(ram_adr), 32'h030);
        end
        @(negedge clk);
        #1;
        chk("hold_cpu_hold", 32'(cpu_hold), 1);
        chk("hold_dma_gnt", 32'(dma_gnt), 1);
        chk("hold_adr", 32'(ram_adr), 32'h031);
        @(negedge clk);
        dma_req = 0;
        #1;
        chk("resume_hold", 32'(cpu_hold), 0);
        chk("resume_adr", 32'(ram_adr), 32'h030);

        // Reset asserted before a granted DMA read returns
        @(negedge clk);
        idle_inputs();
        dma_req = 1;
        #1;
        chk("rstmid_gnt", 32'(dma_gnt), 1);
        rst_n = 1'b0;
        dma_req = 0;
        @(posedge clk);
        #1;
        chk("rstmid_rvalid", 32'(rvalid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cpu_req = 1; dma_req = 1;
        #1;
        chk("rstmid_arb_hold", 32'(cpu_hold), 0);
        chk("rstmid_arb_en", 32'(ram_en), 1);
        @(posedge clk);
        #1;
        chk("rstmid_rvalid_cpu", 32'(rvalid), 32'b001);

        // Perf: 3 conflict cycles, then 5 DMA grants
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            cpu_req = 1; dma_req = 1;
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            cpu_req = 0; dma_req = 1;
        end
        @(negedge clk);
        idle_inputs();
        #1;
`ifdef DRAM_ARB_PERF_EN
        chk("perf_gnt1", 32'(perf_gnt1), 5);
        chk("perf_conf", 32'(perf_conf), 3);
`else
        chk("perf_gnt1", 32'(perf_gnt1), 0);
        chk("perf_conf", 32'(perf_conf), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
